// File: rtl/bullet_fire_sched_pkg.sv
// rtl/bullet_fire_sched_pkg.sv - shared constants, state encoding and helpers for the fire scheduler
package bullet_fire_sched_pkg;

    localparam int unsigned BULLET_NUM_DEF     = 8;
    localparam int unsigned BULLET_NUM_BIT_LEN = 3;
    localparam int unsigned CNT_MAX_SHOOT      = 25_000_000;
    localparam logic [31:0] DOUBLE_MODE_CYCLES = 32'd2_500_000_000;

    localparam logic BULLET_MODE_SINGLE = 1'b0;
    localparam logic BULLET_MODE_DOUBLE = 1'b1;

    typedef enum logic [1:0] {
        BFS_IDLE  = 2'd0,
        BFS_COUNT = 2'd1,
        BFS_FIRE  = 2'd2
    } bfs_state_e;

    // Next slot index with wrap from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_free_picker.sv
// rtl/rr_free_picker.sv - combinational round-robin pick of the lowest free slot at or after a pointer
module rr_free_picker
    import bullet_fire_sched_pkg::*;
#(
    parameter int unsigned BULLET_NUM = BULLET_NUM_DEF,
    parameter int unsigned IDX_W      = BULLET_NUM_BIT_LEN
) (
    input  logic [BULLET_NUM-1:0] free_i,
    input  logic [IDX_W-1:0]      rr_ptr_i,
    output logic                  any_free_o,
    output logic [IDX_W-1:0]      pick_idx_o
);

    logic             found_hi;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Scan downward so the last hit is the lowest index; keep separate winners above/below the pointer.
    always_comb begin
        found_hi = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(BULLET_NUM) - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                lo_idx = IDX_W'(i);
                if (i >= int'(rr_ptr_i)) begin
                    hi_idx   = IDX_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        any_free_o = |free_i;
        pick_idx_o = found_hi ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/bullet_fire_sched.sv
// rtl/bullet_fire_sched.sv - periodic bullet fire scheduler with round-robin slot pick and double-mode timer
module bullet_fire_sched
    import bullet_fire_sched_pkg::*;
#(
    parameter int unsigned BULLET_NUM    = BULLET_NUM_DEF,
    parameter int unsigned IDX_W         = BULLET_NUM_BIT_LEN,
    parameter int unsigned SHOOT_PERIOD  = CNT_MAX_SHOOT,
    parameter logic [31:0] DOUBLE_CYCLES = DOUBLE_MODE_CYCLES
) (
    input  logic                  clk_run,
    input  logic                  rst,
    input  logic                  run_i,
    input  logic                  powerup_i,
    input  logic [BULLET_NUM-1:0] slot_busy_i,
    output logic                  shoot_o,
    output logic [IDX_W-1:0]      shoot_idx_o,
    output logic                  shoot_mode_o,
    output logic                  double_active_o,
    output logic                  miss_o
);

    localparam int unsigned CNT_W    = (SHOOT_PERIOD > 1) ? $clog2(SHOOT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOOT_PERIOD - 1);

    bfs_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [31:0]           timer_q;
    logic [31:0]           timer_d;
    logic                  shoot_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  mode_q;
    logic                  active_q;
    logic                  miss_q;
    logic [BULLET_NUM-1:0] busy_meta_q;
    logic [BULLET_NUM-1:0] busy_sync_q;
    logic                  any_free;
    logic [IDX_W-1:0]      pick_idx;

    // Two-flop synchronizer per slot bit from the video clock domain.
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            busy_meta_q <= '0;
            busy_sync_q <= '0;
        end else begin
            busy_meta_q <= slot_busy_i;
            busy_sync_q <= busy_meta_q;
        end
    end

    rr_free_picker #(
        .BULLET_NUM (BULLET_NUM),
        .IDX_W      (IDX_W)
    ) u_picker (
        .free_i     (~busy_sync_q),
        .rr_ptr_i   (rr_ptr_q),
        .any_free_o (any_free),
        .pick_idx_o (pick_idx)
    );

    // Power-up timer: reload has priority over the final decrement; frozen while paused.
    always_comb begin
        timer_d = timer_q;
        if (powerup_i) begin
            timer_d = DOUBLE_CYCLES;
        end else if (run_i && (timer_q != 32'd0)) begin
            timer_d = timer_q - 32'd1;
        end
    end

    // Timer register and its registered non-zero flag.
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            timer_q  <= '0;
            active_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            active_q <= (timer_d != 32'd0);
        end
    end

    // Fire FSM: period counter, attempt evaluation, slot/mode latch and single-cycle pulses.
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state_q  <= BFS_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            shoot_q  <= 1'b0;
            idx_q    <= '0;
            mode_q   <= BULLET_MODE_SINGLE;
            miss_q   <= 1'b0;
        end else begin
            shoot_q <= 1'b0;
            miss_q  <= 1'b0;
            case (state_q)
                BFS_IDLE, BFS_COUNT: begin
                    if (!run_i) begin
                        state_q <= BFS_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (any_free) begin
                            state_q  <= BFS_FIRE;
                            shoot_q  <= 1'b1;
                            idx_q    <= pick_idx;
                            mode_q   <= active_q ? BULLET_MODE_DOUBLE : BULLET_MODE_SINGLE;
                            rr_ptr_q <= IDX_W'(wrap_inc(32'(pick_idx), BULLET_NUM));
                        end else begin
                            state_q <= BFS_COUNT;
                            miss_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= BFS_COUNT;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                BFS_FIRE: begin
                    if (run_i) begin
                        state_q <= BFS_COUNT;
                        cnt_q   <= cnt_q + 1'b1;
                    end else begin
                        state_q <= BFS_IDLE;
                    end
                end
                default: state_q <= BFS_IDLE;
            endcase
        end
    end

    assign shoot_o         = shoot_q;
    assign shoot_idx_o     = idx_q;
    assign shoot_mode_o    = mode_q;
    assign double_active_o = active_q;
    assign miss_o          = miss_q;

endmodule

// File: tb/tb_bullet_fire_sched.sv
// tb/tb_bullet_fire_sched.sv - self-checking bench for bullet_fire_sched against a behavioural model
module tb_bullet_fire_sched;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int P  = 4;
    localparam int DC = 20;

    logic          clk_run = 1'b0;
    logic          rst     = 1'b1;
    logic          run_i   = 1'b0;
    logic          powerup_i = 1'b0;
    logic [N-1:0]  slot_busy_i = '0;
    logic          shoot_o;
    logic [IW-1:0] shoot_idx_o;
    logic          shoot_mode_o;
    logic          double_active_o;
    logic          miss_o;

    int checks = 0;
    int errors = 0;

    bullet_fire_sched #(
        .BULLET_NUM    (N),
        .IDX_W         (IW),
        .SHOOT_PERIOD  (P),
        .DOUBLE_CYCLES (32'(DC))
    ) dut (
        .clk_run         (clk_run),
        .rst             (rst),
        .run_i           (run_i),
        .powerup_i       (powerup_i),
        .slot_busy_i     (slot_busy_i),
        .shoot_o         (shoot_o),
        .shoot_idx_o     (shoot_idx_o),
        .shoot_mode_o    (shoot_mode_o),
        .double_active_o (double_active_o),
        .miss_o          (miss_o)
    );

    always #5 clk_run = ~clk_run;

    // Behavioural model state
    int m_cnt, m_rr, m_timer, m_idx;
    bit m_shoot, m_miss, m_mode, m_active;
    logic [N-1:0] m_s1, m_s2;

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: one step per clock from the sampled inputs; async reset clears everything.
    always @(posedge clk_run or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_rr = 0; m_timer = 0; m_idx = 0;
            m_shoot = 0; m_miss = 0; m_mode = 0; m_active = 0;
            m_s1 = '0; m_s2 = '0;
        end else begin
            logic [N-1:0] fr;
            int pick;
            fr = ~m_s2;
            m_shoot = 0;
            m_miss = 0;
            if (run_i) begin
                if (m_cnt == P - 1) begin
                    m_cnt = 0;
                    pick = -1;
                    for (int k = 0; k < N; k++)
                        if (pick < 0 && fr[(m_rr + k) % N]) pick = (m_rr + k) % N;
                    if (pick >= 0) begin
                        m_shoot = 1;
                        m_idx = pick;
                        m_mode = m_active;
                        m_rr = (pick + 1) % N;
                    end else begin
                        m_miss = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end
            if (powerup_i) m_timer = DC;
            else if (run_i && m_timer > 0) m_timer--;
            m_active = (m_timer != 0);
            m_s2 = m_s1;
            m_s1 = slot_busy_i;
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk_run) begin
        check("shoot_o", int'(shoot_o), int'(m_shoot));
        check("miss_o", int'(miss_o), int'(m_miss));
        check("shoot_idx_o", int'(shoot_idx_o), m_idx);
        check("shoot_mode_o", int'(shoot_mode_o), int'(m_mode));
        check("double_active_o", int'(double_active_o), int'(m_active));
    end

    task automatic step();
        @(posedge clk_run);
        #1;
    endtask

    task automatic wait_shoot(input int maxc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!shoot_o && cyc < maxc);
        if (!shoot_o) begin
            errors++;
            checks++;
            $display("FAIL wait_shoot: no shoot within %0d cycles", maxc);
        end
    endtask

    initial begin
        int cyc, shots, misses, bad;
        repeat (3) step();
        check("rst shoot", int'(shoot_o), 0);
        check("rst idx", int'(shoot_idx_o), 0);
        check("rst mode", int'(shoot_mode_o), 0);
        check("rst active", int'(double_active_o), 0);
        check("rst miss", int'(miss_o), 0);
        rst = 1'b0;
        step(); step();

        // Free-running fire with all slots free
        run_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            check("period shoot", int'(shoot_o), (c % 4 == 0) ? 1 : 0);
            if (c % 4 == 0) begin
                check("period idx", int'(shoot_idx_o), (c / 4 - 1) % 4);
                check("period mode", int'(shoot_mode_o), 0);
            end
        end

        // Round-robin picks
        rst = 1'b1; run_i = 1'b0; step(); rst = 1'b0;
        slot_busy_i = 4'b1011; step(); step(); step();
        run_i = 1'b1;
        wait_shoot(8, cyc); check("rr idx 1011", int'(shoot_idx_o), 2);
        slot_busy_i = 4'b0111;
        wait_shoot(8, cyc); check("rr idx 0111", int'(shoot_idx_o), 3);
        slot_busy_i = 4'b1110;
        wait_shoot(8, cyc); check("rr idx 1110", int'(shoot_idx_o), 0);

        // No free slot: miss only
        slot_busy_i = 4'b1111;
        shots = 0; misses = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            shots += int'(shoot_o);
            misses += int'(miss_o);
        end
        check("full misses", misses, 3);
        check("full shots", shots, 0);
        slot_busy_i = 4'b1101;
        wait_shoot(8, cyc);
        check("freed latency", cyc, 4);
        check("freed idx", int'(shoot_idx_o), 1);

        // Power-up and reload at timer=1
        slot_busy_i = 4'b0000;
        powerup_i = 1'b1; step(); powerup_i = 1'b0;
        check("pu active", int'(double_active_o), 1);
        shots = 0; bad = 0;
        for (int c = 0; c < 19; c++) begin
            step();
            if (shoot_o) begin
                shots++;
                if (!shoot_mode_o) bad++;
            end
        end
        check("double shots", shots >= 4 ? 1 : 0, 1);
        check("double mode", bad, 0);
        powerup_i = 1'b1; step(); powerup_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 19; c++) begin
            step();
            if (!double_active_o) bad++;
        end
        check("reload holds", bad, 0);
        step();
        check("active falls", int'(double_active_o), 0);

        // Pause at counter=2
        powerup_i = 1'b1; step(); powerup_i = 1'b0;
        wait_shoot(8, cyc);
        step(); step();
        run_i = 1'b0;
        shots = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            shots += int'(shoot_o);
        end
        check("pause shots", shots, 0);
        run_i = 1'b1;
        step(); check("resume c1", int'(shoot_o), 0);
        step(); check("resume c2", int'(shoot_o), 1);

        // Reset while a fire is pending
        wait_shoot(8, cyc);
        step(); step(); step();
        rst = 1'b1;
        #1;
        check("arst shoot", int'(shoot_o), 0);
        check("arst idx", int'(shoot_idx_o), 0);
        check("arst mode", int'(shoot_mode_o), 0);
        check("arst active", int'(double_active_o), 0);
        check("arst miss", int'(miss_o), 0);
        step();
        check("arst no fire", int'(shoot_o), 0);
        rst = 1'b0;
        wait_shoot(8, cyc);
        check("post rst idx", int'(shoot_idx_o), 0);
        check("post rst mode", int'(shoot_mode_o), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            run_i       = ($urandom_range(9) != 0);
            slot_busy_i = N'($urandom);
            powerup_i   = ($urandom_range(40) == 0);
            rst         = ($urandom_range(200) == 0);
            step();
            rst = 1'b0;
        end
        powerup_i = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
